// File: rtl/my_serial_adder.sv
// Bit-serial unsigned adder, LSB first. One bit per clock through a full adder
// made of two half adders, with the carry held in a register between steps.

module my_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// state | meaning
// IDLE  | waiting for start; operands load on the accepting edge
// RUN   | one operand bit pair consumed per edge, LSB first
// DONE  | single-cycle done pulse; sum/carry_out hold the new result
module my_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("my_serial_adder: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic p_bit, g0_bit, s_bit, g1_bit, c_next;

  my_half_adder u_ha0 (
    .a_i (opa_q[0]),
    .b_i (opb_q[0]),
    .s_o (p_bit),
    .c_o (g0_bit)
  );

  my_half_adder u_ha1 (
    .a_i (p_bit),
    .b_i (c_q),
    .s_o (s_bit),
    .c_o (g1_bit)
  );

  assign c_next = g0_bit | g1_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {s_bit, acc_q[WIDTH-1:1]};
        opa_d = {1'b0, opa_q[WIDTH-1:1]};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        c_d   = c_next;
        if (cnt_q == LAST) begin
          // counter parks on the last bit rather than wrapping
          sum_d   = acc_d;
          cout_d  = c_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: doc/my_serial_adder.md
# my_serial_adder

- Bit-serial unsigned adder, LSB first; adds two WIDTH-bit operands over WIDTH clock cycles.
- Per-bit arithmetic is a full-adder cell built from two `my_half_adder` instances plus an OR of their carries.
- Carry is held in a register between bit-steps.
- Sits directly downstream of `my_half_adder` and is the first sequential arithmetic block built on it.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request an addition; sampled on rising edge; honoured only in IDLE.
- a  input  WIDTH  operand A; sampled on the edge that accepts start.
- b  input  WIDTH  operand B; sampled on the edge that accepts start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse marking sum/carry_out updated.
- sum  output  WIDTH  result a+b mod 2^WIDTH; held until the next done.
- carry_out  output  1  carry out of bit WIDTH-1; held with sum.

## Operation
- States are IDLE, RUN and DONE; reset state is IDLE.
- IDLE, start=1:
  - a and b load into internal shift registers opA and opB.
  - The carry register clears to 0 and the bit counter clears to 0.
  - Next state is RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - s = opA[0]^opB[0]^c; c_next = (opA[0]&opB[0]) | (c&(opA[0]^opB[0])).
  - s shifts into the MSB of an internal accumulator, which shifts right.
  - opA and opB shift right with 0 fill.
  - c <= c_next; counter increments.
- RUN, edge processing bit WIDTH-1 (counter == WIDTH-1):
  - The accumulator's final value (including that bit) copies to sum, and c_next copies to carry_out.
  - done <= 1; next state is DONE.
- DONE: done <= 0 on the next edge; next state is IDLE.
- start is ignored in RUN and DONE; no queuing, no error flag.
- a and b may change freely after the accepting edge; they are only sampled on that edge.
- sum and carry_out never show partial results; they change only on the edge that raises done.
- Counter width is clog2(WIDTH) bits; it never wraps within one operation.
- All arithmetic is unsigned; overflow is reported only via carry_out.

## Timing
- Reset values: busy=0, done=0, sum=0, carry_out=0. Internal registers (opA, opB, accumulator, carry, counter) are also 0.
- Reset applies immediately on rst_n falling, independent of clk.
- Reset mid-operation aborts the addition; state returns to IDLE and no done is produced.
- The first start is accepted on the first rising edge after rst_n is high.
- The accepting edge is T0. busy is high from T0 through T(WIDTH).
- Bits 0..WIDTH-1 are processed on edges T1..T(WIDTH).
- done, sum and carry_out update at T(WIDTH); done is high for exactly one cycle, T(WIDTH) to T(WIDTH+1).
- Latency from the accepting edge to done is WIDTH cycles.
- The earliest next accepting edge is T(WIDTH+2) (state is IDLE after T(WIDTH+1)).
- Minimum issue interval is WIDTH+2 cycles.
- start held high continuously produces back-to-back operations at that interval.
- done, busy, sum and carry_out are registered outputs with no combinational path from inputs.

## Test plan
All scenarios use WIDTH=8.
- Reset then idle: hold rst_n=0 for 2 cycles, release with start=0 for 20 cycles -> busy=0, done=0, sum=0x00 and carry_out=0 throughout.
- Basic add: a=0x5A, b=0x25, start pulsed for 1 cycle -> done exactly 8 cycles after the accepting edge; sum=0x7F, carry_out=0; busy high for 8 cycles.
- Carry ripple: a=0xFF, b=0x01 -> sum=0x00, carry_out=1.
- Then a=0xFF, b=0xFF -> sum=0xFE, carry_out=1.
- Then a=0x80, b=0x80 -> sum=0x00, carry_out=1.
- Busy/hold behaviour: start a=0x10, b=0x20; drive start=1 with a=0xAA, b=0x55 during RUN -> first done gives sum=0x30, carry_out=0, and sum stays 0x30 while RUN is in progress. Because start is still held high, the held request is accepted on T(WIDTH+2) and the next done gives 0xFF.
- Reset mid-operation: start a=0x7F, b=0x01; assert rst_n=0 asynchronously 3 cycles in, between edges -> outputs go to 0 immediately, no done pulse. After release, a fresh start with a=0x03, b=0x04 yields sum=0x07, carry_out=0.
- Exhaustive sweep, checked against a+b:
  - All 256x256 operand pairs issued back-to-back with start held high.
  - sum and carry_out compared against the reference result at every done.
  - done-to-done spacing is exactly 10 cycles.
